// File: rtl/alu_cmd_driver.sv
// Queues ALU commands in a DEPTH-entry FIFO and issues them one at a time: holds operands for LAT cycles, then returns the result.
// Optional ALU_CMD_DRIVER_DIV0_TRAP_EN rejects divide/remainder by zero without issuing it.
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_sel,
  input  logic [63:0]  cmd_a,
  input  logic [63:0]  cmd_b,
  input  logic [3:0]   cmd_tag,
  output logic [4:0]   alu_sel,
  output logic [63:0]  alu_a,
  output logic [63:0]  alu_b,
  input  logic [127:0] alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic [3:0]   rsp_tag,
  output logic         rsp_err,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q, state_d;
  logic [4:0]    alu_sel_q, alu_sel_d;
  logic [63:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]    hold_q, hold_d;
  logic [127:0]  rsp_data_q, rsp_data_d, cap;
  logic [3:0]    rsp_tag_q, rsp_tag_d;
  logic          rsp_err_q, rsp_err_d;
  logic          push, pop, reject, trap;
  cmd_t          head;

  assign cmd_ready = rst_n && (cnt_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_q[rd_ptr_q];

`ifdef ALU_CMD_DRIVER_DIV0_TRAP_EN
  assign trap = ((head.sel == 5'b00011) || (head.sel == 5'b00100)) && (head.b == 64'd0);
`else
  assign trap = 1'b0;
`endif
  assign reject = (head.sel > 5'b10110) || trap;

  // Only add and multiply produce results wider than 64 bits.
  always_comb begin
    case (alu_sel_q)
      5'b00000: cap = {63'd0, alu_c[64:0]};
      5'b00010: cap = alu_c;
      default:  cap = {64'd0, alu_c[63:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b, tag: cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_sel_d  = alu_sel_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    hold_d     = hold_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop       = 1'b1;
          rsp_tag_d = head.tag;
          if (reject) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            alu_sel_d = head.sel;
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            hold_d    = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hold_q == 4'(LAT - 1)) begin
          rsp_data_d = cap;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      hold_q     <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      hold_q     <= hold_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: vector table plus burst/backpressure and mid-flight reset sequences, scoreboard-checked.
module tb_alu_cmd_driver;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;
`ifdef ALU_CMD_DRIVER_DIV0_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  localparam logic [63:0] GARB = 64'hA5A5_A5A5_A5A5_A5A5;

  logic         clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [4:0]   cmd_sel, alu_sel;
  logic [63:0]  cmd_a, cmd_b, alu_a, alu_b;
  logic [3:0]   cmd_tag, rsp_tag;
  logic [127:0] alu_c, rsp_data;

  alu_cmd_driver #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  // ALU model: unused upper result bits carry garbage so the driver's zero-extension is exercised.
  always_comb begin
    case (alu_sel)
      5'b00000: alu_c = {63'h5A5A_5A5A_5A5A_5A5A, {1'b0, alu_a} + {1'b0, alu_b}};
      5'b00001: alu_c = {GARB, alu_a - alu_b};
      5'b00010: alu_c = {64'd0, alu_a} * {64'd0, alu_b};
      5'b00011: alu_c = {GARB, (alu_b == 64'd0) ? 64'd0 : alu_a / alu_b};
      5'b00100: alu_c = {GARB, (alu_b == 64'd0) ? 64'd0 : alu_a % alu_b};
      5'b00101: alu_c = {GARB, alu_a & alu_b};
      5'b00110: alu_c = {GARB, alu_a | alu_b};
      default:  alu_c = {GARB, alu_a ^ alu_b};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         err;
  } exp_t;

  typedef struct {
    logic [4:0]   sel;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [3:0]   tag;
    logic [127:0] data;
    logic         err;
  } vec_t;

  exp_t sb[$];
  int   hs_cyc[$];
  exp_t mon_e;
  vec_t vecs[12];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_tag", 128'(rsp_tag), 128'(mon_e.tag));
        chk("rsp_err", 128'(rsp_err), 128'(mon_e.err));
      end
      hs_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] t, input logic [127:0] ed, input logic ee, output int acc);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_tag = t;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept", 128'(cmd_ready), 128'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    sb.push_back('{data: ed, tag: t, err: ee});
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, cnt;
    logic [4:0]  last_sel;
    logic [63:0] last_a, last_b;
    vecs[0]  = '{5'b00000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, 128'h1_0000_0000_0000_0000, 1'b0};
    vecs[1]  = '{5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0};
    vecs[2]  = '{5'b00001, 64'd10, 64'd3, 4'd1, 128'd7, 1'b0};
    vecs[3]  = '{5'b00001, 64'd3, 64'd10, 4'd10, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFF9, 1'b0};
    vecs[4]  = '{5'b00011, 64'd100, 64'd7, 4'd2, 128'd14, 1'b0};
    vecs[5]  = '{5'b11111, 64'd1, 64'd2, 4'd7, 128'd0, 1'b1};
    vecs[6]  = '{5'b10110, 64'hF0, 64'h0F, 4'd4, 128'hFF, 1'b0};
    vecs[7]  = '{5'b10111, 64'd5, 64'd6, 4'd6, 128'd0, 1'b1};
    vecs[8]  = '{5'b00011, 64'd10, 64'd0, 4'd8, 128'd0, TRAP};
    vecs[9]  = '{5'b00100, 64'd17, 64'd0, 4'd9, 128'd0, TRAP};
    vecs[10] = '{5'b00101, 64'hFF00, 64'h0F0F, 4'd11, 128'h0F00, 1'b0};
    vecs[11] = '{5'b00000, 64'd5, 64'd6, 4'd12, 128'd11, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 128'(cmd_ready), 128'd0);
    chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_rsp_data", rsp_data, 128'd0);
    chk("reset_alu_a", 128'(alu_a), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 128'(cmd_ready), 128'd1);
    @(posedge clk);
    #1;

    last_sel = '0; last_a = '0; last_b = '0;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].data, vecs[i].err, acc);
      do @(negedge clk); while (!rsp_valid && (cyc - acc) < 40);
      chk("latency", 128'(cyc - acc), vecs[i].err ? 128'd1 : 128'(LAT + 1));
      @(posedge clk);
      #1;
      if (!vecs[i].err) begin
        last_sel = vecs[i].sel; last_a = vecs[i].a; last_b = vecs[i].b;
      end
      chk("alu_sel_hold", 128'(alu_sel), 128'(last_sel));
      chk("alu_a_hold", 128'(alu_a), 128'(last_a));
      chk("alu_b_hold", 128'(alu_b), 128'(last_b));
    end
    drain("vec_drain");

    // Backpressure: one command parks in RESP while four fill the FIFO.
    rsp_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      send(5'b00000, 64'(k), 64'(k), 4'(k), 128'(2 * k), 1'b0, acc);
    @(negedge clk);
    chk("full_cmd_ready", 128'(cmd_ready), 128'd0);
    chk("full_busy", 128'(busy), 128'd1);
    chk("full_rsp_valid", 128'(rsp_valid), 128'd1);
    repeat (4) @(negedge clk);
    chk("full_cmd_ready_held", 128'(cmd_ready), 128'd0);
    @(posedge clk);
    #1;
    hs_cyc.delete();
    rsp_ready = 1'b1;
    drain("burst_drain");
    chk("burst_rsp_count", 128'(hs_cyc.size()), 128'd5);
    if (hs_cyc.size() == 5)
      for (int j = 1; j < 5; j++)
        chk("burst_gap", 128'(hs_cyc[j] - hs_cyc[j-1]), 128'(LAT + 2));

    // Reset while ISSUE is active with two commands still queued.
    rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(5'b00001, 64'd50, 64'(k), 4'(k), 128'(50 - k), 1'b0, acc);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rsp_valid && cnt < 40);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_pre_reset", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_rsp_tag", 128'(rsp_tag), 128'd0);
    chk("rst_alu_sel", 128'(alu_sel), 128'd0);
    chk("rst_alu_b", 128'(alu_b), 128'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 128'(cmd_ready), 128'd1);
    rsp_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("no_stale_rsp", 128'(cnt), 128'd0);
    @(posedge clk);
    #1;
    send(5'b00010, 64'd3, 64'd4, 4'd13, 128'd12, 1'b0, acc);
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
